preg_free_list_ctrl: RTL and testbench

- Physical-register free-list manager for the dual-issue rename stage.
- Holds every unmapped physical register in a circular FIFO.
- Grants up to two destination pregs per cycle to rename and accepts up to two released pregs per cycle from retire.
- Raises a stall when rename demand exceeds supply; replaces ad-hoc free-bit scanning with an in-order, cycle-accurate allocator.

---
 rtl/preg_free_list_ctrl_if.sv | 42 ++++
 rtl/preg_free_list_ctrl.sv | 164 ++++++++++++++++
 tb/tb_preg_free_list_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_ctrl_if.sv
// Bundle of the rename-side (allocation) and retire-side (release) signals
// of the physical-register free list. The rename/retire logic holds the
// master view and the free list holds the slave view.
// Optional macro FREELIST_DBL_FREE_CHK_EN adds the dbl_free_err signal.
interface preg_free_list_ctrl_if #(
    parameter int PW = 7
);
    logic          alloc_req_1;
    logic          alloc_req_2;
    logic [PW-1:0] alloc_preg_1;
    logic [PW-1:0] alloc_preg_2;
    logic          alloc_stall;
    logic          free_vld_1;
    logic [PW-1:0] free_preg_1;
    logic          free_vld_2;
    logic [PW-1:0] free_preg_2;
    logic [PW:0]   free_count;
    logic          overflow_err;
`ifdef FREELIST_DBL_FREE_CHK_EN
    logic          dbl_free_err;
`endif

    modport master (
        output alloc_req_1, alloc_req_2,
        output free_vld_1, free_preg_1, free_vld_2, free_preg_2,
        input  alloc_preg_1, alloc_preg_2, alloc_stall,
        input  free_count, overflow_err
`ifdef FREELIST_DBL_FREE_CHK_EN
        , input dbl_free_err
`endif
    );

    modport slave (
        input  alloc_req_1, alloc_req_2,
        input  free_vld_1, free_preg_1, free_vld_2, free_preg_2,
        output alloc_preg_1, alloc_preg_2, alloc_stall,
        output free_count, overflow_err
`ifdef FREELIST_DBL_FREE_CHK_EN
        , output dbl_free_err
`endif
    );
endinterface

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list for a dual-issue rename stage.
// Circular FIFO of unmapped pregs: up to two all-or-nothing grants per cycle
// from the head, up to two releases per cycle appended at the tail.
// Optional macro FREELIST_DBL_FREE_CHK_EN adds a per-preg "in list" vector
// that drops repeated frees and reports them on a sticky dbl_free_err.
module preg_free_list_ctrl #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = NUM_PREGS
) (
    input logic                  clk,
    input logic                  rst_n,
    preg_free_list_ctrl_if.slave fl
);
    localparam int PW        = $clog2(NUM_PREGS);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

    logic [PW-1:0] entry [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf_q;

    logic [1:0]    need;
    logic          stall;
    logic [1:0]    pop_n;
    logic [AW-1:0] head_p1;
    logic [CW-1:0] room;
    logic          raw1;
    logic          raw2;
    logic          v1;
    logic          v2;
    logic          acc1;
    logic          acc2;
    logic [1:0]    push_n;
    logic [AW-1:0] wr2_idx;
    logic          ovf_set;

`ifdef FREELIST_DBL_FREE_CHK_EN
    logic [NUM_PREGS-1:0] in_list;
    logic                 dbl_q;
    logic                 dup1;
    logic                 dup2;
`endif

    // Demand, stall and in-order grants from the head; release acceptance at the tail.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        fl.alloc_preg_1 = '0;
        fl.alloc_preg_2 = '0;

        need    = {1'b0, fl.alloc_req_1} + {1'b0, fl.alloc_req_2};
        // Only the registered count is used, so same-cycle frees cannot feed a grant.
        stall   = CW'(need) > count;
        pop_n   = stall ? 2'd0 : need;
        head_p1 = head + AW'(1);

        // All-or-nothing: a stall suppresses both grants.
        if (!stall) begin
            if (fl.alloc_req_1 && fl.alloc_req_2) begin
                fl.alloc_preg_1 = entry[head];
                fl.alloc_preg_2 = entry[head_p1];
            end else if (fl.alloc_req_2) begin
                fl.alloc_preg_2 = entry[head];
            end else if (fl.alloc_req_1) begin
                fl.alloc_preg_1 = entry[head];
            end
        end

        // p0 is hardwired and never enters the list.
        raw1 = fl.free_vld_1 && (fl.free_preg_1 != '0);
        raw2 = fl.free_vld_2 && (fl.free_preg_2 != '0);
`ifdef FREELIST_DBL_FREE_CHK_EN
        dup1 = raw1 && in_list[fl.free_preg_1];
        dup2 = raw2 && (in_list[fl.free_preg_2] ||
                        (raw1 && (fl.free_preg_1 == fl.free_preg_2)));
        v1   = raw1 && !dup1;
        v2   = raw2 && !dup2;
`else
        v1   = raw1;
        v2   = raw2;
`endif

        // Room counts this cycle's pops; slot 1 has priority, slot 2 is dropped first.
        room    = CW'(DEPTH) - (count - CW'(pop_n));
        acc1    = v1 && (room != '0);
        acc2    = v2 && (room > CW'(acc1));
        push_n  = {1'b0, acc1} + {1'b0, acc2};
        wr2_idx = tail + AW'(acc1);
        ovf_set = (v1 && !acc1) || (v2 && !acc2);
    end

    assign fl.alloc_stall  = stall;
    assign fl.free_count   = count;
    assign fl.overflow_err = ovf_q;

    // Pointer, occupancy and sticky-error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= AW'(INIT_FREE);
            count <= CW'(INIT_FREE);
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count - CW'(pop_n) + CW'(push_n);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage: released pregs are written at tail and tail+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because its initial contents are the free pregs themselves.
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= (i < INIT_FREE) ? PW'(NUM_AREGS + i) : '0;
            end
        end else begin
            if (acc1) begin
                entry[tail] <= fl.free_preg_1;
            end
            if (acc2) begin
                entry[wr2_idx] <= fl.free_preg_2;
            end
        end
    end

`ifdef FREELIST_DBL_FREE_CHK_EN
    // Membership vector: pops clear, pushes set (a push wins over a pop of the same preg).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_list[i] <= (i >= NUM_AREGS);
            end
            dbl_q <= 1'b0;
        end else begin
            if (pop_n != 2'd0) begin
                in_list[entry[head]] <= 1'b0;
            end
            if (pop_n == 2'd2) begin
                in_list[entry[head_p1]] <= 1'b0;
            end
            if (acc1) begin
                in_list[fl.free_preg_1] <= 1'b1;
            end
            if (acc2) begin
                in_list[fl.free_preg_2] <= 1'b1;
            end
            if (dup1 || dup2) begin
                dbl_q <= 1'b1;
            end
        end
    end

    assign fl.dbl_free_err = dbl_q;
`endif

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Scoreboard bench for preg_free_list_ctrl. The driver computes each
// cycle's expected outputs from a queue-based model of the free list and
// pushes them to a scoreboard; a monitor pops and compares every cycle.
// Honours FREELIST_DBL_FREE_CHK_EN when the design is built with it.
module tb_preg_free_list_ctrl;
    localparam int PW = 7;
    localparam int NP = 128;
    localparam int NA = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    preg_free_list_ctrl_if #(.PW(PW)) fl ();

    preg_free_list_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl)
    );

    typedef struct {
        bit stall;
        int p1;
        int p2;
        int cnt;
        bit ovf;
        bit dbl;
        int id;
    } exp_t;

    exp_t sb[$];
    int   fq[$];    // model: free list contents in grant order
    int   pool[$];  // pregs granted and not yet released
    bit   m_ovf;
    bit   m_dbl;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step     = 0;

    task automatic check(input string name, input int act, input int exp_v, input int id);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp_v);
    endtask

    function automatic bit listed(input int p);
        foreach (fq[i]) if (fq[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        fl.alloc_req_1 = 1'b0;
        fl.alloc_req_2 = 1'b0;
        fl.free_vld_1  = 1'b0;
        fl.free_preg_1 = '0;
        fl.free_vld_2  = 1'b0;
        fl.free_preg_2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        idle_inputs();
        rst_n = 1'b0;
        fq.delete();
        for (int i = NA; i < NP; i++) fq.push_back(i);
        pool.delete();
        m_ovf = 1'b0;
        m_dbl = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; the expectation reflects the state before the edge.
    task automatic cycle(input bit r1, input bit r2, input bit fv1, input int fp1,
                         input bit fv2, input int fp2);
        exp_t e;
        int   need;
        bit   ok1;
        bit   ok2;
        @(negedge clk);
        fl.alloc_req_1 = r1;
        fl.alloc_req_2 = r2;
        fl.free_vld_1  = fv1;
        fl.free_preg_1 = PW'(fp1);
        fl.free_vld_2  = fv2;
        fl.free_preg_2 = PW'(fp2);

        need    = int'(r1) + int'(r2);
        e.stall = need > fq.size();
        e.p1    = 0;
        e.p2    = 0;
        e.cnt   = fq.size();
        e.ovf   = m_ovf;
        e.dbl   = m_dbl;
        e.id    = step;
        if (!e.stall) begin
            if (r1 && r2) begin
                e.p1 = fq[0];
                e.p2 = fq[1];
            end else if (r2) begin
                e.p2 = fq[0];
            end else if (r1) begin
                e.p1 = fq[0];
            end
        end
        sb.push_back(e);

        ok1 = fv1 && (fp1 != 0);
        ok2 = fv2 && (fp2 != 0);
`ifdef FREELIST_DBL_FREE_CHK_EN
        if (ok1 && listed(fp1)) begin
            ok1   = 1'b0;
            m_dbl = 1'b1;
        end
        if (ok2 && (listed(fp2) || (fv1 && fp1 != 0 && fp1 == fp2))) begin
            ok2   = 1'b0;
            m_dbl = 1'b1;
        end
`endif
        if (!e.stall) repeat (need) pool.push_back(fq.pop_front());
        if (ok1) begin
            if (fq.size() < NP) fq.push_back(fp1);
            else m_ovf = 1'b1;
        end
        if (ok2) begin
            if (fq.size() < NP) fq.push_back(fp2);
            else m_ovf = 1'b1;
        end
        step++;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("alloc_stall",  int'(fl.alloc_stall),  int'(e.stall), e.id);
                check("alloc_preg_1", int'(fl.alloc_preg_1), e.p1,          e.id);
                check("alloc_preg_2", int'(fl.alloc_preg_2), e.p2,          e.id);
                check("free_count",   int'(fl.free_count),   e.cnt,         e.id);
                check("overflow_err", int'(fl.overflow_err), int'(e.ovf),   e.id);
`ifdef FREELIST_DBL_FREE_CHK_EN
                check("dbl_free_err", int'(fl.dbl_free_err), int'(e.dbl),   e.id);
`endif
            end
        end
    end

    initial begin : driver
        idle_inputs();
        rst_n = 1'b0;

        // Reset state, then a dual grant of 32/33; the following cycle shows 94.
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset mid-operation, then single slot-2 grant followed by slot-1 grant.
        do_reset();
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Drain to one entry, then the empty-boundary sequence.
        while (fq.size() > 1) begin
            if (fq.size() >= 3) cycle(1, 1, 0, 0, 0, 0);
            else cycle(1, 0, 0, 0, 0, 0);
        end
        cycle(1, 1, 0, 0, 0, 0);    // one entry, two requests: stall
        cycle(1, 0, 0, 0, 0, 0);    // single grant empties the list
        cycle(0, 1, 0, 0, 0, 0);    // empty: stall
        cycle(1, 0, 1, 40, 1, 41);  // frees not visible yet: stall
        cycle(1, 0, 0, 0, 0, 0);    // grant 40
        cycle(0, 0, 1, 0, 0, 0);    // free of p0 ignored
        cycle(0, 0, 0, 0, 0, 0);

        // Steady dual alloc/free so both pointers wrap several times.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            int a;
            int b;
            if (pool.size() >= 2) begin
                a = pool.pop_front();
                b = pool.pop_front();
                cycle(1, 1, 1, a, 1, b);
            end else begin
                cycle(1, 1, 0, 0, 0, 0);
            end
        end

`ifdef FREELIST_DBL_FREE_CHK_EN
        // Repeated frees: a listed preg, and two identical same-cycle frees.
        do_reset();
        cycle(0, 0, 1, 50, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 33, 1, 33);
        cycle(0, 0, 0, 0, 0, 0);
`else
        // Overflow: 96 pops, then 129 frees into a 128-entry list.
        do_reset();
        repeat (48) cycle(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cycle(0, 0, 1, (2 * k) % 127 + 1, 1, (2 * k + 1) % 127 + 1);
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
`endif

        // Randomised traffic with occasional p0 and repeated frees.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit r1;
            bit r2;
            bit v1;
            bit v2;
            int p1;
            int p2;
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            v1 = 1'b0;
            v2 = 1'b0;
            p1 = 0;
            p2 = 0;
            if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1;
                p1 = pool.pop_front();
            end
            if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
                v2 = 1'b1;
                p2 = pool.pop_front();
            end
            if ($urandom_range(0, 15) == 0) begin
                v1 = 1'b1;
                p1 = 0;
            end
            if ($urandom_range(0, 31) == 0) begin
                v2 = 1'b1;
                p2 = int'($urandom_range(1, NP - 1));
            end
            cycle(r1, r2, v1, p1, v2, p2);
        end
        cycle(0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #4;
        check("scoreboard_drained", sb.size(), 0, step);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
